// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// One product per accepted start. Latency is fixed at WL RUN steps and does not depend on the operands.
module shift_add_mult_ctrl #(
  parameter int WL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WL-1:0]     multiplicand,
  input  logic [WL-1:0]     multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*WL-1:0]   product
);

  localparam int CW = $clog2(WL) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [2*WL-1:0]     mcand_q, mcand_d;
  logic [WL-1:0]       mplier_q, mplier_d;
  logic [2*WL-1:0]     acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*WL-1:0]     product_q, product_d;
  logic [2*WL-1:0]     step_sum;
  logic                last_step;

  // The partial sum including the current step is needed on the final edge.
  // It is written straight into product, so the result is ready as DONE is entered.
  assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = (count_q == CW'(WL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d  = {{WL{1'b0}}, multiplicand};
        mplier_d = multiplier;
        acc_d    = '0;
        count_d  = '0;
      end
      RUN: begin
        acc_d    = step_sum;
        mcand_d  = {mcand_q[2*WL-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WL-1:1]};
        count_d  = count_q + CW'(1);
        if (last_step) product_d = step_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl: a vector table on a WL=4 instance,
// plus hand-written sequences for multi-cycle corner cases and a WL=8 instance.
module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  shift_add_mult_ctrl #(.WL(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .multiplicand(a4), .multiplier(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_mult_ctrl #(.WL(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept one operation on the selected instance, then measure the latency to done and check the product.
  task automatic run_op(input int w, input int a, input int b, input int exp, input string name);
    int k;
    @(negedge clk);
    if (w == 4) begin a4 = 4'(a); b4 = 4'(b); start4 = 1'b1; end
    else        begin a8 = 8'(a); b8 = 8'(b); start8 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    check({name, " busy_after_E0"}, (w == 4) ? busy4 : busy8, 1);
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (((w == 4) ? done4 : done8) == 1'b1) begin k = n; break; end
    end
    check({name, " latency"}, k, w);
    check({name, " product"}, (w == 4) ? prod4 : prod8, exp);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, (w == 4) ? done4 : done8, 0);
    check({name, " idle_after"}, (w == 4) ? busy4 : busy8, 0);
  endtask

  typedef struct {
    int    a;
    int    b;
    int    exp;
    string name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dcount;
    int prev_done;
    int idle_cnt;
    int k;

    vecs[0] = '{13, 11, 143, "v13x11"};
    vecs[1] = '{15, 15, 225, "v15x15"};
    vecs[2] = '{0,  9,  0,   "v0x9"};
    vecs[3] = '{9,  0,  0,   "v9x0"};
    vecs[4] = '{1,  1,  1,   "v1x1"};

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #12;
    check("reset busy", busy4, 0);
    check("reset done", done4, 0);
    check("reset product", prod4, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op(4, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      if (vecs[i].exp == 143) begin
        repeat (5) @(posedge clk);
        #1 check("hold product", prod4, 143);
      end
    end

    // A start pulse and operand change mid-run must be ignored.
    @(negedge clk); a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk); #1 start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(posedge clk); #1 start4 = 1'b0;
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done4) begin
        dcount++;
        check("ignored_start product", prod4, 42);
      end
    end
    check("ignored_start done_count", dcount, 1);

    // Asynchronous reset between E2 and E3.
    @(negedge clk); a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst busy", busy4, 0);
    check("async_rst done", done4, 0);
    check("async_rst product", prod4, 0);
    @(negedge clk); rst = 1'b0;
    run_op(4, 3, 5, 15, "post_rst3x5");

    // start held high: back-to-back operations every WL+2 cycles.
    @(negedge clk); a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    prev_done = -1; idle_cnt = 0; dcount = 0;
    for (int n = 0; n < 22; n++) begin
      @(posedge clk); #1;
      if (done4) begin
        dcount++;
        check("b2b product", prod4, 15);
        if (prev_done >= 0) begin
          check("b2b period", n - prev_done, 6);
          check("b2b idle_gap", idle_cnt, 1);
        end
        prev_done = n;
        idle_cnt = 0;
      end
      if (!busy4) idle_cnt++;
    end
    check("b2b done_count", dcount >= 3, 1);
    @(negedge clk); start4 = 1'b0;
    k = 0;
    for (int n = 0; n < 10 && busy4; n++) begin
      @(posedge clk); #1; k++;
    end
    check("b2b drain", busy4, 0);

    run_op(8, 255, 255, 65025, "w8_255x255");
    run_op(8, 128, 2, 256, "w8_128x2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
